gf163_digit_feeder: RTL and testbench
=====================================

Name: gf163_digit_feeder

Overview:
- Operand sequencer in front of the 8-digit systolic GF(2^163) multiplier array.
- Latches a 163-bit multiplicand A and multiplier B on a start handshake.
- Holds A and the reduction polynomial G stable on parallel buses for the array.
- Streams B to the array one 8-bit digit per accepted cycle, most-significant digit first, then waits out the array pipeline before signalling completion.

Parameters:
- M, 163, field degree (operand width).
- DIGITS, 8, digit width, bits of B per array step.
- NDIG, 21, digits per operand = ceil(M/DIGITS); B is zero-padded to NDIG*DIGITS = 168 bits.
- DRAIN_CYC, 2, cycles after the last digit before done (array pipeline depth).
- POLY, 163'h...C9 (bits 7,6,3,0 set), low M bits of x^163+x^7+x^6+x^3+1.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; accepted only when busy=0.
- a_in  input  M  multiplicand, sampled on accepted start.
- b_in  input  M  multiplier, sampled on accepted start.
- clear  input  1  synchronous abort to IDLE.
- arr_ready  input  1  array accepts the current digit this cycle.
- a_out  output  M  latched A, stable while busy.
- g_out  output  M  constant POLY.
- b_digit  output  DIGITS  current B digit.
- digit_valid  output  1  b_digit valid.
- first_digit  output  1  current digit is index 0.
- last_digit  output  1  current digit is index NDIG-1.
- busy  output  1  operation in progress.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset (rst_n=0, async): state IDLE; a_out=0, b_digit=0, digit_valid=0, first_digit=0, last_digit=0, busy=0, done=0, digit counter=0, drain counter=0. g_out is always POLY, including during reset.
- States: IDLE, FEED, DRAIN, DONE.
- IDLE:
  - On start=1, latch a_in into a_out and {5'b0,b_in} into the shift register, clear the counter, and go to FEED.
  - busy rises the cycle after start.
  - start while busy=1 is ignored; no queueing.
- FEED:
  - Digit k occupies padded bits [167-8k -: 8], so digit 0 = {5'b0,b_in[162:160]} and digit 20 = b_in[7:0].
  - digit_valid=1 throughout FEED.
  - A digit is transferred when digit_valid & arr_ready. On transfer, shift left by DIGITS and increment the counter.
  - arr_ready=0 stalls: b_digit, counter and flags hold.
  - first_digit=1 while counter==0; last_digit=1 while counter==NDIG-1.
  - Transfer of digit NDIG-1: go to DRAIN; digit_valid and b_digit go to 0 the next cycle.
  - Zero stalls: 21 FEED cycles.
- DRAIN: count DRAIN_CYC cycles, independent of arr_ready, then go to DONE.
- DONE: done=1 for exactly one cycle, busy=0 in the same cycle, next state IDLE.
  - a_out keeps the last operand until the next accepted start.
- Latency: with no stalls, start accepted at cycle 0 gives first digit at cycle 1, last digit at cycle 21, done at cycle 21+DRAIN_CYC+1 = 24.
- clear=1 in any state:
  - Next cycle is IDLE with busy=0, digit_valid=0, done=0; a_out is retained.
  - clear has priority over start in the same cycle; start is not accepted.
- start in the DONE cycle: ignored.
- start one cycle after done: accepted; this is back-to-back operation.
- rst_n asserted mid-FEED: immediate reset values; no done pulse on release.
- arr_ready is ignored outside FEED.
- Counter is ceil(log2(NDIG)) = 5 bits and never exceeds NDIG-1.

Test Plan:
- Basic: a_in=1, b_in=163'h4_0000...0001 (bits 162 and 0), arr_ready=1 -> b_digit sequence 8'h04, then 19×8'h00, then 8'h01; first_digit only on the first, last_digit only on the 21st; done at cycle 24; a_out=1; g_out=POLY.
- Stall: same operands with arr_ready=0 for 3 cycles while digit index 5 is presented -> digit 5 held for 4 cycles, counter frozen; done at cycle 27.
- Busy protection: pulse start with b_in=all-ones during FEED of operand B=163'h1 -> sequence unaffected; a second start after done presents digit 0 = 8'h07 and digits 1–20 = 8'hFF.
- Clear: assert clear at digit 10 -> busy=0 and digit_valid=0 next cycle, no done pulse; start with clear=1 in the same cycle is not accepted.
- Back-to-back: start held high continuously -> starts accepted at cycles 0 and 25; two done pulses exactly 25 cycles apart.
- Async reset: drop rst_n mid-DRAIN, between clock edges -> all outputs at reset values immediately; no done pulse after release.

Source files
------------

// File: rtl/gf163_digit_feeder_if.sv
// Operand and handshake bundle between the host, the digit feeder
// and the systolic GF(2^163) multiplier array.
interface gf163_digit_feeder_if #(
    parameter int M      = 163,
    parameter int DIGITS = 8
);
    logic              start;
    logic [M-1:0]      a_in;
    logic [M-1:0]      b_in;
    logic              clear;
    logic              arr_ready;
    logic [M-1:0]      a_out;
    logic [M-1:0]      g_out;
    logic [DIGITS-1:0] b_digit;
    logic              digit_valid;
    logic              first_digit;
    logic              last_digit;
    logic              busy;
    logic              done;

    modport master (
        output start, a_in, b_in, clear, arr_ready,
        input  a_out, g_out, b_digit, digit_valid,
        input  first_digit, last_digit, busy, done
    );

    modport slave (
        input  start, a_in, b_in, clear, arr_ready,
        output a_out, g_out, b_digit, digit_valid,
        output first_digit, last_digit, busy, done
    );
endinterface

// File: rtl/gf163_digit_feeder.sv
// Operand sequencer for the 8-digit systolic GF(2^163) multiplier:
// holds A/G, streams B MSD-first, then waits out the array pipeline.
module gf163_digit_feeder #(
    parameter int M         = 163,
    parameter int DIGITS    = 8,
    parameter int NDIG      = 21,
    parameter int DRAIN_CYC = 2,
    parameter logic [M-1:0] POLY = {{(M-8){1'b0}}, 8'hC9}
) (
    input logic                  clk,
    input logic                  rst_n,
    gf163_digit_feeder_if.slave  bus
);
    localparam int PW = NDIG * DIGITS;
    localparam int CW = $clog2(NDIG);
    localparam int DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FEED,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [M-1:0]    r_a;
    logic [PW-1:0]   r_sr;
    logic [CW-1:0]   r_cnt;
    logic [DW-1:0]   r_drn;
    logic            w_feed;
    logic            w_accept;
    logic            w_xfer;
    logic            w_last;
    logic            w_drn_end;

    assign w_feed    = (r_state == S_FEED);
    assign w_accept  = (r_state == S_IDLE) & bus.start & ~bus.clear;
    assign w_xfer    = w_feed & bus.arr_ready;
    assign w_last    = (r_cnt == CW'(NDIG - 1));
    assign w_drn_end = (r_drn == DW'(DRAIN_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_FEED;
            S_FEED:  if (w_xfer && w_last) w_next = S_DRAIN;
            S_DRAIN: if (w_drn_end) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        // abort wins over every transition, including a start in IDLE
        if (bus.clear) w_next = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a   <= '0;
            r_sr  <= '0;
            r_cnt <= '0;
            r_drn <= '0;
        end else if (bus.clear) begin
            r_cnt <= '0;
            r_drn <= '0;
        end else begin
            if (w_accept) begin
                r_a   <= bus.a_in;
                r_sr  <= {{(PW-M){1'b0}}, bus.b_in};
                r_cnt <= '0;
            end
            if (w_xfer) begin
                r_sr  <= r_sr << DIGITS;
                r_cnt <= w_last ? '0 : r_cnt + CW'(1);
            end
            if (r_state == S_DRAIN) begin
                r_drn <= w_drn_end ? '0 : r_drn + DW'(1);
            end
        end
    end

    assign bus.a_out       = r_a;
    assign bus.g_out       = POLY;
    assign bus.b_digit     = w_feed ? r_sr[PW-1 -: DIGITS] : '0;
    assign bus.digit_valid = w_feed;
    assign bus.first_digit = w_feed & (r_cnt == '0);
    assign bus.last_digit  = w_feed & w_last;
    assign bus.busy        = w_feed | (r_state == S_DRAIN);
    assign bus.done        = (r_state == S_DONE);
endmodule

// File: tb/tb_gf163_digit_feeder.sv
// Scoreboard bench for gf163_digit_feeder: expected digits are queued
// at start and popped as the array accepts them.
module tb_gf163_digit_feeder;
    localparam logic [162:0] POLY = 163'hC9;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   cyc = 0;
    logic [9:0] exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    gf163_digit_feeder_if #(.M(163), .DIGITS(8)) bus ();

    gf163_digit_feeder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // every accepted digit is checked against the head of the queue
    always @(negedge clk) begin : mon
        logic [9:0] got;
        logic [9:0] want;
        if (rst_n && bus.digit_valid && bus.arr_ready) begin
            got = {bus.first_digit, bus.last_digit, bus.b_digit};
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL digit_extra got=%h required=none", got);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    n_fail++;
                    $display("FAIL digit got=%h required=%h", got, want);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_op(input logic [162:0] b);
        logic [167:0] p;
        p = {5'b0, b};
        for (int k = 0; k < 21; k++)
            exp_q.push_back({k == 0, k == 20, p[167-8*k -: 8]});
    endtask

    function automatic logic [162:0] rnd163();
        logic [191:0] t;
        t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        return t[162:0];
    endfunction

    // drives one operation; done_cyc is -1 if done never appears
    task automatic run_op(input logic [162:0] a, input logic [162:0] b,
                          input int stall_at, input int stall_len,
                          input int poke_at, output int done_cyc);
        int t0, idx, st, n;
        push_op(b);
        bus.a_in = a;
        bus.b_in = b;
        bus.start = 1'b1;
        bus.arr_ready = 1'b0;
        t0 = cyc;
        idx = 0;
        st = 0;
        done_cyc = -1;
        for (int i = 0; i < 200; i++) begin
            step();
            n = cyc - t0;
            bus.start = (n == poke_at);
            if (n == poke_at) begin
                bus.a_in = '1;
                bus.b_in = '1;
            end
            if (bus.done) begin
                done_cyc = n;
                break;
            end
            if (bus.digit_valid) begin
                if (idx == stall_at && st < stall_len) begin
                    bus.arr_ready = 1'b0;
                    st++;
                end else begin
                    bus.arr_ready = 1'b1;
                    idx++;
                end
            end else begin
                bus.arr_ready = 1'b0;
            end
        end
        bus.start = 1'b0;
        bus.arr_ready = 1'b0;
        step();
    endtask

    task automatic test_reset();
        #2;
        n_tests++;
        if ({bus.a_out, bus.b_digit, bus.digit_valid, bus.first_digit,
             bus.last_digit, bus.busy, bus.done} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got=%h busy=%b required=0",
                     bus.a_out, bus.busy);
        end
        n_tests++;
        if (bus.g_out !== POLY) begin
            n_fail++;
            $display("FAIL reset_g got=%h required=%h", bus.g_out, POLY);
        end
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        int d;
        logic [162:0] b;
        b = '0;
        b[162] = 1'b1;
        b[0] = 1'b1;
        run_op(163'h1, b, -1, 0, -1, d);
        n_tests++;
        if (d !== 24) begin
            n_fail++;
            $display("FAIL basic_done_cycle got=%0d required=24", d);
        end
        n_tests++;
        if (bus.a_out !== 163'h1 || bus.g_out !== POLY) begin
            n_fail++;
            $display("FAIL basic_a_g got=%h/%h required=1/%h",
                     bus.a_out, bus.g_out, POLY);
        end
        n_tests++;
        if ({bus.busy, bus.digit_valid, bus.done} !== 3'b000) begin
            n_fail++;
            $display("FAIL basic_idle got=%b required=000",
                     {bus.busy, bus.digit_valid, bus.done});
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL basic_left got=%0d required=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_stall();
        int d;
        logic [162:0] b;
        b = '0;
        b[162] = 1'b1;
        b[0] = 1'b1;
        run_op(163'h1, b, 5, 3, -1, d);
        n_tests++;
        if (d !== 27) begin
            n_fail++;
            $display("FAIL stall_done_cycle got=%0d required=27", d);
        end
        run_op(163'h3, rnd163(), 20, 2, -1, d);
        n_tests++;
        if (d !== 26) begin
            n_fail++;
            $display("FAIL stall_last_done got=%0d required=26", d);
        end
        run_op(163'h3, rnd163(), 0, 1, -1, d);
        n_tests++;
        if (d !== 25) begin
            n_fail++;
            $display("FAIL stall_first_done got=%0d required=25", d);
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL stall_left got=%0d required=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_busy_protect();
        int d;
        run_op(163'h5, 163'h1, -1, 0, 8, d);
        n_tests++;
        if (d !== 24) begin
            n_fail++;
            $display("FAIL busy_done_cycle got=%0d required=24", d);
        end
        n_tests++;
        if (bus.a_out !== 163'h5) begin
            n_fail++;
            $display("FAIL busy_a_out got=%h required=5", bus.a_out);
        end
        run_op(163'h7, '1, -1, 0, -1, d);
        n_tests++;
        if (d !== 24) begin
            n_fail++;
            $display("FAIL busy_second_done got=%0d required=24", d);
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL busy_left got=%0d required=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_clear();
        int idx, dones;
        logic found;
        logic [162:0] a;
        a = rnd163();
        push_op(rnd163());
        bus.a_in = a;
        bus.b_in = exp_q.size() > 0 ? '0 : '0;
        bus.start = 1'b1;
        idx = 0;
        found = 1'b0;
        exp_q.delete();
        push_op(163'h0);
        for (int i = 0; i < 40; i++) begin
            step();
            bus.start = 1'b0;
            if (bus.digit_valid) begin
                if (idx == 10) begin
                    bus.clear = 1'b1;
                    bus.arr_ready = 1'b0;
                    found = 1'b1;
                    break;
                end
                bus.arr_ready = 1'b1;
                idx++;
            end
        end
        n_tests++;
        if (found !== 1'b1) begin
            n_fail++;
            $display("FAIL clear_reach got=%0d required=10", idx);
        end
        step();
        bus.clear = 1'b0;
        exp_q.delete();
        n_tests++;
        if ({bus.busy, bus.digit_valid, bus.done} !== 3'b000) begin
            n_fail++;
            $display("FAIL clear_idle got=%b required=000",
                     {bus.busy, bus.digit_valid, bus.done});
        end
        n_tests++;
        if (bus.a_out !== a) begin
            n_fail++;
            $display("FAIL clear_a_out got=%h required=%h", bus.a_out, a);
        end
        dones = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (bus.done) dones++;
        end
        n_tests++;
        if (dones !== 0) begin
            n_fail++;
            $display("FAIL clear_no_done got=%0d required=0", dones);
        end
        bus.start = 1'b1;
        bus.clear = 1'b1;
        step();
        bus.start = 1'b0;
        bus.clear = 1'b0;
        n_tests++;
        if ({bus.busy, bus.digit_valid} !== 2'b00) begin
            n_fail++;
            $display("FAIL clear_start_prio got=%b required=00",
                     {bus.busy, bus.digit_valid});
        end
        step();
    endtask

    task automatic test_back_to_back();
        int t0, n, k;
        int d[2];
        logic [162:0] a2;
        logic [162:0] b1;
        logic [162:0] b2;
        a2 = rnd163();
        b1 = rnd163();
        b2 = rnd163();
        push_op(b1);
        push_op(b2);
        bus.a_in = 163'h9;
        bus.b_in = b1;
        bus.start = 1'b1;
        bus.arr_ready = 1'b1;
        t0 = cyc;
        k = 0;
        d[0] = -1;
        d[1] = -1;
        for (int i = 0; i < 80; i++) begin
            step();
            n = cyc - t0;
            if (n == 2) begin
                bus.a_in = a2;
                bus.b_in = b2;
            end
            if (bus.done) begin
                d[k] = n;
                k++;
                if (k == 2) break;
            end
        end
        bus.start = 1'b0;
        bus.arr_ready = 1'b0;
        step();
        n_tests++;
        if (d[0] !== 24 || d[1] !== 49) begin
            n_fail++;
            $display("FAIL b2b_done got=%0d,%0d required=24,49", d[0], d[1]);
        end
        n_tests++;
        if (bus.a_out !== a2) begin
            n_fail++;
            $display("FAIL b2b_a_out got=%h required=%h", bus.a_out, a2);
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_left got=%0d required=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_async_reset();
        int t0, dones;
        push_op(rnd163());
        bus.a_in = 163'hABC;
        bus.b_in = '0;
        exp_q.delete();
        push_op(163'h0);
        bus.start = 1'b1;
        bus.arr_ready = 1'b1;
        t0 = cyc;
        for (int i = 0; i < 22; i++) begin
            step();
            bus.start = 1'b0;
        end
        n_tests++;
        if (cyc - t0 !== 22 || {bus.busy, bus.digit_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL areset_drain got=%b required=10",
                     {bus.busy, bus.digit_valid});
        end
        #3;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({bus.a_out, bus.b_digit, bus.digit_valid, bus.first_digit,
             bus.last_digit, bus.busy, bus.done} !== '0) begin
            n_fail++;
            $display("FAIL areset_outputs got=%h busy=%b required=0",
                     bus.a_out, bus.busy);
        end
        n_tests++;
        if (bus.g_out !== POLY) begin
            n_fail++;
            $display("FAIL areset_g got=%h required=%h", bus.g_out, POLY);
        end
        #3;
        rst_n = 1'b1;
        bus.arr_ready = 1'b0;
        dones = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (bus.done || bus.busy) dones++;
        end
        n_tests++;
        if (dones !== 0) begin
            n_fail++;
            $display("FAIL areset_no_done got=%0d required=0", dones);
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL areset_left got=%0d required=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.clear = 1'b0;
        bus.arr_ready = 1'b0;
        bus.a_in = '0;
        bus.b_in = '0;
        test_reset();
        test_basic();
        test_stall();
        test_busy_protect();
        test_clear();
        test_back_to_back();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule
